// File: rtl/lut_ni_loader.sv
// Writer side of the neighbour-intensity weight LUT: packs a byte stream MSB-first
// into DATA_W-bit words and writes them to LUT addresses 0..DEPTH-1, one pass per i_start.
`timescale 1ns/1ps
module lut_ni_loader #(
    parameter int BYTE_W = 8,
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BPW   = DATA_W / BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SH_W  = (BPW > 1) ? DATA_W - BYTE_W : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [SH_W-1:0]     r_shift;
    logic                r_byte_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic [DATA_W-1:0]   w_word;

    assign w_xfer = i_byte_valid && r_byte_ready;

    // The incoming byte lands at the LSB end, so the first byte of a word ends up on top.
    generate
        if (BPW > 1) begin : g_pack
            assign w_word = {r_shift, i_byte};
        end else begin : g_pass
            assign w_word = i_byte;
        end
    endgenerate

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, exactly like the flops it describes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_addr       <= '0;
            r_shift      <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: default-low assignment makes the write strobe a single-cycle pulse.
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_LOAD;
                        r_byte_cnt   <= '0;
                        r_addr       <= '0;
                        r_shift      <= '0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_shift <= w_word[SH_W-1:0];
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_addr;
                            r_wr_data  <= w_word;
                            // The last word ends the pass; the address never steps past DEPTH-1.
                            if (r_addr == LAST_ADDR) begin
                                r_state      <= ST_DONE;
                                r_byte_ready <= 1'b0;
                                r_busy       <= 1'b0;
                                r_done       <= 1'b1;
                            end else begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
